skip_decode: RTL and testbench

- Receive-side counterpart of the skip-ring clock generator: recovers the skip mask from a reference clock, the gated (skipped) clock derived from it, and the ring's slot-0 strobe.
- All three inputs are sampled asynchronously on a fast system clock (board mCLK). The block frames slots, reassembles the LEN-bit mask and tracks lock.
- It reports the recovered mask, a match against an expected mask, and an error count. Used for self-check and LED/debug readout of a running skip ring.

---
 rtl/skip_decode.sv | 200 ++++++++++++++++++++
 tb/tb_skip_decode.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/skip_decode.sv
// skip_decode
//   Receive side of the skip-ring clock generator. Samples the reference
//   clock, the skipped clock and the slot-0 strobe on iCLK. Frames one slot per
//   reference edge and rebuilds the LEN-bit skip mask. Tracks lock and counts
//   framing errors and loss-of-clock timeouts.
//
// Ports
//   iCLK     system clock, all logic on its rising edge
//   iRST_N   asynchronous active-low reset
//   iE       enable; low forces HUNT and freezes counters and outputs
//   iREF     reference clock (asynchronous)
//   iSCLK    skipped clock (asynchronous)
//   iST      slot-0 strobe (asynchronous)
//   iMASK    expected mask, sampled only when a frame completes
//   oMASK    last complete recovered mask, bit k = slot k
//   oVALID   one-cycle pulse when oMASK updates
//   oMATCH   oMASK == iMASK, captured with oVALID
//   oLOCK    high while in LOCKED
//   oERR     one-cycle pulse per framing error or timeout
//   oERRCNT  saturating count of framing errors plus timeouts
module skip_decode #(
    parameter int LEN     = 16,
    parameter int TIMEOUT = 67108864,
    parameter int ERRW    = 8
) (
    input  logic            iCLK,
    input  logic            iRST_N,
    input  logic            iE,
    input  logic            iREF,
    input  logic            iSCLK,
    input  logic            iST,
    input  logic [LEN-1:0]  iMASK,
    output logic [LEN-1:0]  oMASK,
    output logic            oVALID,
    output logic            oMATCH,
    output logic            oLOCK,
    output logic            oERR,
    output logic [ERRW-1:0] oERRCNT
);

    localparam int IDXW = $clog2(LEN + 1);
    localparam int BITW = (LEN > 1) ? $clog2(LEN) : 1;
    localparam int TW   = $clog2(TIMEOUT + 1);
    localparam logic [IDXW-1:0] IDX_FULL = IDXW'(LEN);
    localparam logic [TW-1:0]   T_MAX    = TW'(TIMEOUT);

    typedef enum logic [1:0] {HUNT, SYNC, LOCKED} state_t;

    state_t          state, state_n;
    logic            ref_p0, ref_p1, ref_p2;
    logic            sclk_p0, sclk_p1, sclk_p2;
    logic            st_p0, st_p1;
    logic            ref_e, sclk_e, st_sync;
    logic            pulse_seen, pulse_n;
    logic            st_seen, stf_n;
    logic            slot_open, open_n;
    logic [IDXW-1:0] idx, idx_n;
    logic [LEN-1:0]  sr, sr_n;
    logic [TW-1:0]   tcnt, tcnt_n;
    logic            done_c, err_c;

    function automatic logic [ERRW-1:0] sat_inc(input logic [ERRW-1:0] v);
        return (&v) ? v : v + ERRW'(1);
    endfunction

    // Stage p0/p1: two-flop synchronizers; stage p2: edge-detect history
    assign ref_e   = ref_p1 & ~ref_p2;
    assign sclk_e  = sclk_p1 & ~sclk_p2;
    assign st_sync = st_p1;

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state <= HUNT;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        idx_n   = idx;
        sr_n    = sr;
        pulse_n = pulse_seen;
        stf_n   = st_seen;
        open_n  = slot_open;
        tcnt_n  = tcnt;
        done_c  = 1'b0;
        err_c   = 1'b0;
        if (!iE) begin
            state_n = HUNT;
            idx_n   = '0;
            pulse_n = 1'b0;
            stf_n   = 1'b0;
            open_n  = 1'b0;
            tcnt_n  = '0;
        end else if (ref_e) begin
            tcnt_n  = '0;
            // Activity coincident with the reference edge belongs to the new slot
            pulse_n = sclk_e;
            stf_n   = st_sync;
            open_n  = 1'b1;
            // The first edge after HUNT entry only opens a slot; there is
            // nothing framed yet to close
            if (slot_open) begin
                if (state == HUNT) begin
                    if (st_seen) begin
                        sr_n    = '0;
                        sr_n[0] = pulse_seen;
                        idx_n   = IDXW'(1);
                        state_n = SYNC;
                    end
                end else if (st_seen) begin
                    if (idx == IDX_FULL) begin
                        done_c  = 1'b1;
                        state_n = LOCKED;
                    end else begin
                        err_c   = 1'b1;
                        state_n = SYNC;
                    end
                    sr_n    = '0;
                    sr_n[0] = pulse_seen;
                    idx_n   = IDXW'(1);
                end else if (idx != IDX_FULL) begin
                    sr_n[idx[BITW-1:0]] = pulse_seen;
                    idx_n = idx + IDXW'(1);
                end else begin
                    // Strobe missing where slot 0 should be: framing lost
                    err_c   = 1'b1;
                    state_n = HUNT;
                    open_n  = 1'b0;
                    idx_n   = '0;
                end
            end
        end else begin
            pulse_n = pulse_seen | sclk_e;
            stf_n   = st_seen | st_sync;
            // Counter parks at T_MAX so a lost clock reports only once
            if (tcnt != T_MAX) begin
                tcnt_n = tcnt + TW'(1);
            end else if (state != HUNT) begin
                err_c   = 1'b1;
                state_n = HUNT;
                open_n  = 1'b0;
                idx_n   = '0;
            end
        end
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            ref_p0     <= 1'b0;
            ref_p1     <= 1'b0;
            ref_p2     <= 1'b0;
            sclk_p0    <= 1'b0;
            sclk_p1    <= 1'b0;
            sclk_p2    <= 1'b0;
            st_p0      <= 1'b0;
            st_p1      <= 1'b0;
            pulse_seen <= 1'b0;
            st_seen    <= 1'b0;
            slot_open  <= 1'b0;
            idx        <= '0;
            sr         <= '0;
            tcnt       <= '0;
            oMASK      <= '0;
            oVALID     <= 1'b0;
            oMATCH     <= 1'b0;
            oERR       <= 1'b0;
            oERRCNT    <= '0;
        end else begin
            ref_p0     <= iREF;
            ref_p1     <= ref_p0;
            ref_p2     <= ref_p1;
            sclk_p0    <= iSCLK;
            sclk_p1    <= sclk_p0;
            sclk_p2    <= sclk_p1;
            st_p0      <= iST;
            st_p1      <= st_p0;
            pulse_seen <= pulse_n;
            st_seen    <= stf_n;
            slot_open  <= open_n;
            idx        <= idx_n;
            sr         <= sr_n;
            tcnt       <= tcnt_n;
            // Output stage: registered one cycle after the closing edge
            oVALID     <= done_c;
            oERR       <= err_c;
            if (done_c) begin
                oMASK  <= sr;
                oMATCH <= (sr == iMASK);
            end
            if (err_c) begin
                oERRCNT <= sat_inc(oERRCNT);
            end
        end
    end

    assign oLOCK = (state == LOCKED);

endmodule

// File: tb/tb_skip_decode.sv
module tb_skip_decode;

    localparam int LEN     = 16;
    localparam int TIMEOUT = 100;
    localparam int ERRW    = 8;
    localparam int ERRMAX  = (1 << ERRW) - 1;
    localparam int M_HUNT  = 0;
    localparam int M_SYNC  = 1;
    localparam int M_LOCK  = 2;

    logic            iCLK = 1'b0;
    logic            iRST_N, iE, iREF, iSCLK, iST;
    logic [LEN-1:0]  iMASK;
    logic [LEN-1:0]  oMASK;
    logic            oVALID, oMATCH, oLOCK, oERR;
    logic [ERRW-1:0] oERRCNT;

    always #5 iCLK = ~iCLK;

    skip_decode #(.LEN(LEN), .TIMEOUT(TIMEOUT), .ERRW(ERRW)) dut (
        .iCLK(iCLK), .iRST_N(iRST_N), .iE(iE), .iREF(iREF), .iSCLK(iSCLK),
        .iST(iST), .iMASK(iMASK), .oMASK(oMASK), .oVALID(oVALID),
        .oMATCH(oMATCH), .oLOCK(oLOCK), .oERR(oERR), .oERRCNT(oERRCNT)
    );

    int n_checks = 0;
    int n_err    = 0;

    // Cycle counter and pulse monitor
    int cyc = 0, mon_valid = 0, mon_err = 0, err_cyc = 0;
    always @(posedge iCLK) cyc <= cyc + 1;
    always @(negedge iCLK) begin
        if (oVALID === 1'b1) mon_valid <= mon_valid + 1;
        if (oERR === 1'b1) begin
            mon_err <= mon_err + 1;
            err_cyc <= cyc;
        end
    end

    // Slot-level reference model: a frame is the list of pulse bits seen
    // since the last strobe slot
    int             mode = M_HUNT;
    bit             opened = 1'b0;
    bit             frame_q[$];
    bit             cur_b = 1'b0, cur_s = 1'b0;
    int             exp_valid = 0, exp_errs = 0, exp_errcnt = 0;
    logic [LEN-1:0] exp_mask = '0;
    bit             exp_match = 1'b0;
    int             last_rise = 0;

    // Ring generator state
    logic [LEN-1:0] ring_mask = 16'hCCCC;
    int             ring_ph = 0;
    bit             jitter = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [LEN-1:0] pack_frame();
        logic [LEN-1:0] m;
        m = '0;
        for (int i = 0; i < frame_q.size(); i++) m[i] = frame_q[i];
        return m;
    endfunction

    task automatic model_err();
        exp_errs++;
        if (exp_errcnt < ERRMAX) exp_errcnt++;
    endtask

    task automatic model_close(input bit b, input bit s);
        if (mode == M_HUNT) begin
            if (s) begin
                frame_q.delete();
                frame_q.push_back(b);
                mode = M_SYNC;
            end
        end else if (s) begin
            if (frame_q.size() == LEN) begin
                exp_mask  = pack_frame();
                exp_match = (exp_mask == iMASK);
                exp_valid++;
                mode = M_LOCK;
            end else begin
                model_err();
                mode = M_SYNC;
            end
            frame_q.delete();
            frame_q.push_back(b);
        end else if (frame_q.size() < LEN) begin
            frame_q.push_back(b);
        end else begin
            model_err();
            mode   = M_HUNT;
            opened = 1'b0;
            frame_q.delete();
        end
    endtask

    task automatic model_to_hunt();
        mode   = M_HUNT;
        opened = 1'b0;
        frame_q.delete();
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_valid_count"}, 32'(mon_valid), 32'(exp_valid));
        chk({tag, "_err_count"}, 32'(mon_err), 32'(exp_errs));
        chk({tag, "_lock"}, 32'(oLOCK), 32'(mode == M_LOCK));
        chk({tag, "_errcnt"}, 32'(oERRCNT), 32'(exp_errcnt));
        chk({tag, "_mask"}, 32'(oMASK), 32'(exp_mask));
        chk({tag, "_match"}, 32'(oMATCH), 32'(exp_match));
    endtask

    // One reference period of 40 iCLK; starts and ends on a falling clock edge
    task automatic run_slot(input bit b, input bit s, input int off, input bit do_chk);
        if (iE && iRST_N) begin
            if (!opened) opened = 1'b1;
            else model_close(cur_b, cur_s);
        end
        cur_b = b;
        cur_s = s;
        last_rise = cyc;
        iREF  = 1'b1;
        iST   = s;
        iSCLK = (off == 0) ? b : 1'b0;
        if (off > 0) begin
            repeat (off) @(negedge iCLK);
            iSCLK = b;
        end
        repeat (20 - off) @(negedge iCLK);
        iREF  = 1'b0;
        iSCLK = 1'b0;
        repeat (20) @(negedge iCLK);
        if (do_chk) check_all("slot");
    endtask

    task automatic run_ring(input int n, input bit do_chk);
        int off;
        for (int i = 0; i < n; i++) begin
            off = jitter ? int'($urandom_range(0, 15)) : 0;
            run_slot(ring_mask[ring_ph], ring_ph == 0, off, do_chk);
            ring_ph = (ring_ph + 1) % LEN;
        end
    endtask

    task automatic align_ring();
        while (ring_ph != 0) run_ring(1, 1'b1);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_mask"}, 32'(oMASK), 0);
        chk({tag, "_valid"}, 32'(oVALID), 0);
        chk({tag, "_match"}, 32'(oMATCH), 0);
        chk({tag, "_lock"}, 32'(oLOCK), 0);
        chk({tag, "_err"}, 32'(oERR), 0);
        chk({tag, "_errcnt"}, 32'(oERRCNT), 0);
    endtask

    initial begin
        int e0, v0, d;
        logic [LEN-1:0] prev;

        iRST_N = 1'b0;
        iE     = 1'b1;
        iREF   = 1'b0;
        iSCLK  = 1'b0;
        iST    = 1'b0;
        iMASK  = 16'hCCCC;
        repeat (3) @(negedge iCLK);
        check_zero("reset");
        iRST_N = 1'b1;
        @(negedge iCLK);

        // Lock onto a steady CCCC ring: two complete frames
        run_ring(2 * LEN + 2, 1'b1);
        chk("lock_valid_frames", 32'(mon_valid), 2);
        chk("lock_mask", 32'(oMASK), 32'h0000CCCC);
        chk("lock_match", 32'(oMATCH), 1);
        chk("lock_lock", 32'(oLOCK), 1);
        chk("lock_errcnt", 32'(oERRCNT), 0);

        // Expected mask differs
        iMASK = 16'h3333;
        run_ring(LEN, 1'b1);
        chk("nomatch_mask", 32'(oMASK), 32'h0000CCCC);
        chk("nomatch_match", 32'(oMATCH), 0);
        chk("nomatch_lock", 32'(oLOCK), 1);
        iMASK = 16'hCCCC;

        // Ring phase jumps: strobe shows up at slot 10
        while (ring_ph != 10) run_ring(1, 1'b1);
        e0 = mon_err;
        ring_ph = 0;
        run_ring(2, 1'b1);
        chk("jump_err_pulses", 32'(mon_err - e0), 1);
        chk("jump_errcnt", 32'(oERRCNT), 1);
        chk("jump_lock", 32'(oLOCK), 0);
        run_ring(LEN, 1'b1);
        chk("jump_relock", 32'(oLOCK), 1);

        // Strobe suppressed for one frame
        align_ring();
        e0 = mon_err;
        run_slot(ring_mask[0], 1'b0, 0, 1'b1);
        ring_ph = 1;
        run_ring(1, 1'b1);
        chk("supp_err_pulses", 32'(mon_err - e0), 1);
        chk("supp_errcnt", 32'(oERRCNT), 2);
        chk("supp_lock", 32'(oLOCK), 0);
        run_ring(2 * LEN - 1, 1'b1);
        chk("supp_not_yet_locked", 32'(oLOCK), 0);
        run_ring(1, 1'b1);
        chk("supp_relock", 32'(oLOCK), 1);

        // Random masks, random pulse offsets, random iMASK, occasional missing strobe
        jitter = 1'b1;
        align_ring();
        for (int f = 0; f < 8; f++) begin
            prev      = ring_mask;
            ring_mask = LEN'($urandom);
            iMASK     = ($urandom_range(0, 1) == 1) ? prev : LEN'($urandom);
            if ($urandom_range(0, 5) == 0) begin
                run_slot(ring_mask[0], 1'b0, 0, 1'b1);
                ring_ph = 1;
                run_ring(LEN - 1, 1'b1);
            end else begin
                run_ring(LEN, 1'b1);
            end
        end
        jitter = 1'b0;

        // Loss of reference clock
        run_ring(2 * LEN + 2, 1'b1);
        chk("pre_timeout_lock", 32'(oLOCK), 1);
        e0 = mon_err;
        run_ring(1, 1'b0);
        repeat (80) @(negedge iCLK);
        model_err();
        model_to_hunt();
        check_all("timeout");
        d = err_cyc - last_rise;
        chk("timeout_pulses", 32'(mon_err - e0), 1);
        chk("timeout_latency_in_window", 32'(d >= TIMEOUT && d <= TIMEOUT + 10), 1);
        chk("timeout_lock", 32'(oLOCK), 0);
        run_ring(2 * LEN + 2, 1'b1);
        chk("timeout_relock", 32'(oLOCK), 1);

        // Enable low while locked
        e0 = mon_err;
        v0 = mon_valid;
        iE = 1'b0;
        model_to_hunt();
        @(posedge iCLK);
        #1;
        chk("disable_lock_next_cycle", 32'(oLOCK), 0);
        @(negedge iCLK);
        run_ring(LEN + 5, 1'b1);
        ring_ph = 0;
        run_ring(LEN + 3, 1'b1);
        chk("disable_no_valid", 32'(mon_valid - v0), 0);
        chk("disable_no_err", 32'(mon_err - e0), 0);
        iE = 1'b1;
        run_ring(2 * LEN + 2, 1'b1);
        chk("enable_relock", 32'(oLOCK), 1);

        // Asynchronous reset mid-frame
        ring_mask = 16'hCCCC;
        iMASK     = 16'hCCCC;
        align_ring();
        run_ring(2 * LEN + 5, 1'b1);
        #2;
        iRST_N = 1'b0;
        #1;
        check_zero("async_reset");
        model_to_hunt();
        exp_mask   = '0;
        exp_match  = 1'b0;
        exp_errcnt = 0;
        repeat (2) @(negedge iCLK);
        iRST_N = 1'b1;
        @(negedge iCLK);
        run_ring(2 * LEN + 2, 1'b1);
        chk("post_reset_mask", 32'(oMASK), 32'h0000CCCC);
        chk("post_reset_lock", 32'(oLOCK), 1);

        // Strobe in every slot: repeated framing errors saturate the counter
        for (int i = 0; i < 300; i++) run_slot(ring_mask[i % LEN], 1'b1, 0, 1'b0);
        check_all("saturate");
        chk("saturate_errcnt", 32'(oERRCNT), ERRMAX);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
